// File: rtl/mac_accumulator.sv
// mac_accumulator
// Sums BURST_LEN unsigned 64-bit products into an ACC_W-bit accumulator and
// holds the finished sum until the downstream consumer takes it.
// States: IDLE (waiting for the first product), ACCUM (burst in progress),
// HOLD (result presented on acc_out with acc_valid high).
// Optional build macro MAC_SATURATE_EN: an addition with a carry out clamps
// acc_out to all ones for the rest of the burst. When the macro is not defined,
// acc_out wraps modulo 2^ACC_W. The ovf flag behaves the same in both builds.
module mac_accumulator #(
    parameter int ACC_W     = 72,
    parameter int BURST_LEN = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             clear,
    input  logic             prod_valid,
    input  logic [63:0]      prod,
    output logic             prod_ready,
    output logic [ACC_W-1:0] acc_out,
    output logic             acc_valid,
    input  logic             acc_ready,
    output logic [7:0]       cnt,
    output logic             ovf
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ACCUM = 2'd1;
    localparam logic [1:0] HOLD  = 2'd2;

    localparam logic [7:0] LAST_CNT = 8'(BURST_LEN);

    logic [1:0]       state_q, state_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [7:0]       cnt_q, cnt_d;
    logic             ovf_q, ovf_d;

    logic             take;
    logic [ACC_W:0]   sum_full;
    logic [7:0]       cnt_inc;

    // Turns the carry-extended sum into the stored accumulator value.
    // In the saturating build, a carry out pins the value at all ones. Once
    // pinned, any nonzero product carries again and a zero product leaves the
    // value unchanged, so the clamp holds for the rest of the burst without
    // extra state.
    function automatic logic [ACC_W-1:0] resolve_sum(input logic [ACC_W:0] full);
`ifdef MAC_SATURATE_EN
        if (full[ACC_W]) begin
            return '1;
        end
        return full[ACC_W-1:0];
`else
        return full[ACC_W-1:0];
`endif
    endfunction

    // prod_ready is gated by the reset pin directly, so it drops at once
    // without waiting for a clock edge.
    assign prod_ready = reset && (state_q != HOLD);
    assign take       = prod_valid && prod_ready;
    assign sum_full   = {1'b0, acc_q} + {1'b0, ACC_W'(prod)};
    assign cnt_inc    = cnt_q + 8'd1;

    assign acc_out    = acc_q;
    assign cnt        = cnt_q;
    assign ovf        = ovf_q;
    assign acc_valid  = (state_q == HOLD);

    // Next-state and datapath selection. clear overrides any transfer or
    // handoff that happens on the same edge.
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        ovf_d   = ovf_q;
        if (clear) begin
            state_d = IDLE;
            acc_d   = '0;
            cnt_d   = '0;
            ovf_d   = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (take) begin
                        acc_d   = ACC_W'(prod);
                        cnt_d   = 8'd1;
                        ovf_d   = 1'b0;
                        state_d = (LAST_CNT == 8'd1) ? HOLD : ACCUM;
                    end
                end
                ACCUM: begin
                    if (take) begin
                        acc_d = resolve_sum(sum_full);
                        cnt_d = cnt_inc;
                        ovf_d = ovf_q | sum_full[ACC_W];
                        if (cnt_inc == LAST_CNT) begin
                            state_d = HOLD;
                        end
                    end
                end
                HOLD: begin
                    // A product offered on the handoff edge is not taken,
                    // because prod_ready is low for the whole HOLD cycle.
                    if (acc_ready) begin
                        state_d = IDLE;
                        acc_d   = '0;
                        cnt_d   = '0;
                        ovf_d   = 1'b0;
                    end
                end
                default: begin
                    state_d = IDLE;
                    acc_d   = '0;
                    cnt_d   = '0;
                    ovf_d   = 1'b0;
                end
            endcase
        end
    end

    // State and accumulator registers. Reset discards any partial or held result.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            acc_q   <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
        end
    end

endmodule

// File: tb/tb_mac_accumulator.sv
// Bench for mac_accumulator: a burst-of-8 instance with a 72-bit accumulator,
// plus a burst-of-2 instance with a 64-bit accumulator for the overflow case.
`timescale 1ns/1ps
module tb_mac_accumulator;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic reset;

    // Burst-of-8 instance, 72-bit accumulator
    logic        clear8, pv8, ar8, pr8, av8, ovf8;
    logic [63:0] p8;
    logic [71:0] acc8;
    logic [7:0]  cnt8;

    // Burst-of-2 instance, 64-bit accumulator
    logic        clear2, pv2, ar2, pr2, av2, ovf2;
    logic [63:0] p2;
    logic [63:0] acc2;
    logic [7:0]  cnt2;

    mac_accumulator #(.ACC_W(72), .BURST_LEN(8)) dut8 (
        .clock(clock), .reset(reset), .clear(clear8),
        .prod_valid(pv8), .prod(p8), .prod_ready(pr8),
        .acc_out(acc8), .acc_valid(av8), .acc_ready(ar8),
        .cnt(cnt8), .ovf(ovf8)
    );

    mac_accumulator #(.ACC_W(64), .BURST_LEN(2)) dut2 (
        .clock(clock), .reset(reset), .clear(clear2),
        .prod_valid(pv2), .prod(p2), .prod_ready(pr2),
        .acc_out(acc2), .acc_valid(av2), .acc_ready(ar2),
        .cnt(cnt2), .ovf(ovf2)
    );

`ifdef MAC_SATURATE_EN
    localparam logic [63:0] OVF_SUM = 64'hFFFF_FFFF_FFFF_FFFF;
`else
    localparam logic [63:0] OVF_SUM = 64'd1;
`endif

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [71:0] acc;
        logic [7:0]  cnt;
        logic        ovf;
    } res_t;

    res_t sb[$];

    // Reference model of the burst-of-8 instance
    logic [72:0] m_acc;
    int          m_cnt;
    logic        m_ovf;
    bit          m_hold;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_idle();
        m_acc  = '0;
        m_cnt  = 0;
        m_ovf  = 1'b0;
        m_hold = 1'b0;
    endtask

    // Drive the burst-of-8 inputs for the next edge and predict its effect.
    task automatic drive8(input logic v, input logic [63:0] p, input logic clr);
        res_t e;
        pv8    = v;
        p8     = p;
        clear8 = clr;
        if (clr) begin
            model_idle();
        end else if (v && !m_hold) begin
            if (m_cnt == 0) begin
                m_acc = 73'(p);
                m_ovf = 1'b0;
            end else begin
                m_acc = {1'b0, m_acc[71:0]} + 73'(p);
                if (m_acc[72]) m_ovf = 1'b1;
                m_acc[72] = 1'b0;
            end
            m_cnt++;
            if (m_cnt == 8) begin
                m_hold = 1'b1;
                e.acc  = m_acc[71:0];
                e.cnt  = 8'(m_cnt);
                e.ovf  = m_ovf;
                sb.push_back(e);
            end
        end
    endtask

    // Wait, with a bound, for a result from the burst-of-8 instance and score it.
    task automatic expect8(input string tag);
        res_t e;
        int n = 0;
        while (av8 !== 1'b1 && n < 20) begin
            @(negedge clock);
            n++;
        end
        check({tag, "_valid"}, 128'(av8), 128'(1'b1));
        check({tag, "_sbdepth"}, 128'(sb.size()), 128'(1));
        if (sb.size() > 0) begin
            e = sb.pop_front();
            check({tag, "_acc"}, 128'(acc8), 128'(e.acc));
            check({tag, "_cnt"}, 128'(cnt8), 128'(e.cnt));
            check({tag, "_ovf"}, 128'(ovf8), 128'(e.ovf));
        end
    endtask

    task automatic handoff8(input string tag);
        ar8 = 1'b1;
        @(negedge clock);
        ar8 = 1'b0;
        model_idle();
        check({tag, "_av_after"}, 128'(av8), 128'(1'b0));
        check({tag, "_acc_after"}, 128'(acc8), 128'(0));
        check({tag, "_cnt_after"}, 128'(cnt8), 128'(0));
    endtask

    initial begin
        reset = 1'b0;
        clear8 = 1'b0; pv8 = 1'b0; p8 = '0; ar8 = 1'b0;
        clear2 = 1'b0; pv2 = 1'b0; p2 = '0; ar2 = 1'b0;
        model_idle();

        // Reset state
        @(negedge clock);
        check("rst_ready", 128'(pr8), 128'(1'b0));
        check("rst_acc", 128'(acc8), 128'(0));
        check("rst_cnt", 128'(cnt8), 128'(0));
        check("rst_valid", 128'(av8), 128'(1'b0));
        check("rst_ovf", 128'(ovf8), 128'(1'b0));
        @(negedge clock);
        reset = 1'b1;

        // Products 1..8 on consecutive cycles
        for (int i = 1; i <= 8; i++) begin
            drive8(1'b1, 64'(i), 1'b0);
            @(negedge clock);
            if (i < 8) check("b36_no_valid", 128'(av8), 128'(1'b0));
        end
        drive8(1'b0, 64'd0, 1'b0);
        check("b36_acc_const", 128'(acc8), 128'(36));
        expect8("b36");

        // HOLD with acc_ready low and a product offered
        drive8(1'b1, 64'd99, 1'b0);
        for (int k = 0; k < 5; k++) begin
            @(negedge clock);
            check("hold_acc", 128'(acc8), 128'(36));
            check("hold_ready", 128'(pr8), 128'(1'b0));
            check("hold_cnt", 128'(cnt8), 128'(8));
            check("hold_valid", 128'(av8), 128'(1'b1));
        end
        ar8 = 1'b1;
        @(negedge clock);
        ar8 = 1'b0;
        model_idle();
        check("hand_valid", 128'(av8), 128'(1'b0));
        check("hand_acc", 128'(acc8), 128'(0));
        check("hand_cnt", 128'(cnt8), 128'(0));
        check("hand_ready", 128'(pr8), 128'(1'b1));
        drive8(1'b0, 64'd0, 1'b0);

        // Clear after 3 of 5 transfers, with a transfer offered on the clear edge
        for (int i = 0; i < 3; i++) begin
            drive8(1'b1, 64'd5, 1'b0);
            @(negedge clock);
        end
        check("clr_pre_cnt", 128'(cnt8), 128'(3));
        drive8(1'b1, 64'd5, 1'b1);
        @(negedge clock);
        check("clr_cnt", 128'(cnt8), 128'(0));
        check("clr_acc", 128'(acc8), 128'(0));
        check("clr_valid", 128'(av8), 128'(1'b0));
        check("clr_ready", 128'(pr8), 128'(1'b1));
        for (int i = 0; i < 8; i++) begin
            drive8(1'b1, 64'd5, 1'b0);
            @(negedge clock);
        end
        drive8(1'b0, 64'd0, 1'b0);
        check("b40_acc_const", 128'(acc8), 128'(40));
        expect8("b40");
        handoff8("b40");

        // prod_valid toggling: 8 transfers over 16 cycles
        for (int k = 0; k < 16; k++) begin
            drive8((k % 2) == 0, 64'd3, 1'b0);
            @(negedge clock);
            if (k < 14) begin
                check("tog_no_valid", 128'(av8), 128'(1'b0));
                check("tog_cnt", 128'(cnt8), 128'(k / 2 + 1));
            end else begin
                check("tog_valid", 128'(av8), 128'(1'b1));
            end
        end
        drive8(1'b0, 64'd0, 1'b0);
        check("b24_acc_const", 128'(acc8), 128'(24));
        expect8("b24");
        handoff8("b24");

        // Reset pulsed between edges in mid-burst
        for (int i = 0; i < 3; i++) begin
            drive8(1'b1, 64'd7, 1'b0);
            @(negedge clock);
        end
        drive8(1'b0, 64'd0, 1'b0);
        check("mid_cnt", 128'(cnt8), 128'(3));
        #2 reset = 1'b0;
        #1;
        check("async_acc", 128'(acc8), 128'(0));
        check("async_cnt", 128'(cnt8), 128'(0));
        check("async_valid", 128'(av8), 128'(1'b0));
        check("async_ready", 128'(pr8), 128'(1'b0));
        model_idle();
        @(negedge clock);
        reset = 1'b1;
        drive8(1'b1, 64'd2, 1'b0);
        @(negedge clock);
        check("post_rst_cnt", 128'(cnt8), 128'(1));
        check("post_rst_acc", 128'(acc8), 128'(2));
        for (int i = 1; i < 8; i++) begin
            drive8(1'b1, 64'd2, 1'b0);
            @(negedge clock);
        end
        drive8(1'b0, 64'd0, 1'b0);
        expect8("b16");
        handoff8("b16");

        // 64-bit accumulator overflow, burst of 2
        pv2 = 1'b1;
        p2  = 64'hFFFF_FFFF_FFFF_FFFF;
        @(negedge clock);
        check("o2_first_acc", 128'(acc2), 128'(64'hFFFF_FFFF_FFFF_FFFF));
        check("o2_first_ovf", 128'(ovf2), 128'(1'b0));
        p2 = 64'd2;
        @(negedge clock);
        pv2 = 1'b0;
        check("o2_valid", 128'(av2), 128'(1'b1));
        check("o2_ovf", 128'(ovf2), 128'(1'b1));
        check("o2_cnt", 128'(cnt2), 128'(2));
        check("o2_acc", 128'(acc2), 128'(OVF_SUM));
        ar2 = 1'b1;
        @(negedge clock);
        ar2 = 1'b0;
        check("o2_ovf_cleared", 128'(ovf2), 128'(1'b0));
        check("o2_acc_cleared", 128'(acc2), 128'(0));
        pv2 = 1'b1;
        p2  = 64'd3;
        @(negedge clock);
        p2 = 64'd4;
        @(negedge clock);
        pv2 = 1'b0;
        check("n2_acc", 128'(acc2), 128'(7));
        check("n2_ovf", 128'(ovf2), 128'(1'b0));
        check("n2_valid", 128'(av2), 128'(1'b1));
        ar2 = 1'b1;
        @(negedge clock);
        ar2 = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
